// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths, MAC state encoding and Q8.8 limits for the convolution datapath
package cnn_pkg;
    localparam int PROD_W    = 32;
    localparam int DATA_W    = 16;
    localparam int ACC_W     = 40;
    localparam int CNT_W     = 10;
    localparam int FRAC_BITS = 8;
    localparam logic signed [DATA_W-1:0] Q_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] Q_MIN = 16'sh8000;
    typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} mac_state_t;
endpackage

// File: rtl/cnn_requant.sv
// cnn_requant: floor shift to Q8.8, saturate, optional ReLU when CONV_MAC_RELU_EN is defined
module cnn_requant
    import cnn_pkg::*;
#(
    parameter int IN_W = ACC_W
) (
    input  logic signed [IN_W-1:0]   acc,
    output logic        [DATA_W-1:0] data,
    output logic                     sat
);
    localparam logic signed [IN_W-1:0] MAX_EXT = {{(IN_W-DATA_W){Q_MAX[DATA_W-1]}}, Q_MAX};
    localparam logic signed [IN_W-1:0] MIN_EXT = {{(IN_W-DATA_W){Q_MIN[DATA_W-1]}}, Q_MIN};
    logic signed [IN_W-1:0] shifted;
    logic hi, lo;
    // Arithmetic shift floors toward minus infinity; then clip to the Q8.8 range
    always_comb begin
        shifted = acc >>> FRAC_BITS;
        hi = shifted > MAX_EXT;
        lo = shifted < MIN_EXT;
`ifdef CONV_MAC_RELU_EN
        data = hi ? Q_MAX : shifted[IN_W-1] ? '0 : shifted[DATA_W-1:0];
        sat  = hi;
`else
        data = hi ? Q_MAX : lo ? Q_MIN : shifted[DATA_W-1:0];
        sat  = hi | lo;
`endif
    end
endmodule

// File: rtl/conv_mac_accumulator.sv
// conv_mac_accumulator: bias-seeded product accumulation with Q8.8 requantized output (ReLU via CONV_MAC_RELU_EN)
module conv_mac_accumulator
    import cnn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_terms,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              sat_flag,
    output logic              busy
);
    mac_state_t state;
    logic [ACC_W-1:0]  acc, sum, bias_q, rq_in;
    logic [CNT_W-1:0]  cnt, terms;
    logic [DATA_W-1:0] rq_data;
    logic              rq_sat, accept, last;

    assign in_ready  = state == ACCUM;
    assign out_valid = state == OUTPUT;
    assign busy      = state != IDLE;
    assign accept    = in_valid && in_ready;
    assign last      = cnt == terms - CNT_W'(1);
    assign bias_q    = {{(ACC_W-DATA_W-FRAC_BITS){bias[DATA_W-1]}}, bias, {FRAC_BITS{1'b0}}};
    assign sum       = acc + {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
    // In IDLE the only possible result is the bias alone (zero-term pixel)
    assign rq_in     = state == IDLE ? bias_q : sum;

    cnn_requant #(.IN_W(ACC_W)) u_requant (
        .acc  (rq_in),
        .data (rq_data),
        .sat  (rq_sat)
    );

    // Pixel sequencing: seed with bias, accumulate beats, hold result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            terms    <= '0;
            out_data <= '0;
            sat_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    terms <= num_terms;
                    cnt   <= '0;
                    acc   <= bias_q;
                    if (num_terms == '0) begin
                        out_data <= rq_data;
                        sat_flag <= rq_sat;
                        state    <= OUTPUT;
                    end else begin
                        state <= ACCUM;
                    end
                end
                ACCUM: if (accept) begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        out_data <= rq_data;
                        sat_flag <= rq_sat;
                        state    <= OUTPUT;
                    end
                end
                OUTPUT: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
